// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_e      : controller state encoding
//   CNT_W        : width of the seconds/minutes counters
//   SEC_MAX_DEF  : default terminal value of the seconds counter
//   MIN_MAX_DEF  : default terminal value of the minutes counter
package stopwatch_pkg;

  localparam int CNT_W       = 6;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_cnt60.sv
// Mod-(MAX+1) up-counter with enable, synchronous clear and carry-out.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (one step per enabled cycle)
//   clr        : synchronous clear, overrides en
//   cnt_o      : current count, 0..MAX
//   carry_o    : high in the cycle the counter wraps from MAX to 0
module cnt60_en
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o,
  output logic             carry_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max  = (cnt_q == CNT_W'(MAX));
  // Carry is suppressed by clear so a clear never leaks into the next stage.
  assign carry_o = en & ~clr & at_max;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch controller with prescaler and mm:ss counters.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   num              : prescale divisor, tick period in clk cycles (0 acts as 1)
//   btn_run/lap/clr  : debounced button levels; rising edges are the commands
//   sec_out, min_out : displayed time (lap snapshot while in LAP)
//   tick_o           : one-cycle prescaler tick
//   running          : high in RUN or LAP
//   lap_active       : high in LAP
//   ovf              : one-cycle pulse on the 59:59 -> 00:00 wrap
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting, live display
// PAUSE | counting held, prescaler phase kept
// LAP   | counting, display frozen on snapshot
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_W   = 32,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] num,
  input  logic             btn_run,
  input  logic             btn_lap,
  input  logic             btn_clr,
  output logic [5:0]       sec_out,
  output logic [5:0]       min_out,
  output logic             tick_o,
  output logic             running,
  output logic             lap_active,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   pcnt_q, pcnt_d;
  logic               tick_q, tick_d;
  logic               ovf_q, ovf_d;
  logic [2*CNT_W-1:0] snap_q, snap_d;
  logic               btn_run_q, btn_lap_q, btn_clr_q;

  logic               run_edge, lap_edge, clr_edge;
  logic               period_done;
  logic [CNT_W-1:0]   sec_cnt, min_cnt;
  logic               sec_carry, min_carry;

  assign run_edge = btn_run & ~btn_run_q;
  assign lap_edge = btn_lap & ~btn_lap_q;
  assign clr_edge = btn_clr & ~btn_clr_q;

  // num of 0 or 1 both mean "tick every cycle"; the first term also keeps
  // num-1 from underflowing.
  assign period_done = (num <= NUM_W'(1)) || (pcnt_q >= num - NUM_W'(1));

  cnt60_en #(.MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tick_q),
    .clr     (clr_edge),
    .cnt_o   (sec_cnt),
    .carry_o (sec_carry)
  );

  cnt60_en #(.MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (sec_carry),
    .clr     (clr_edge),
    .cnt_o   (min_cnt),
    .carry_o (min_carry)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tick_d  = 1'b0;
    snap_d  = snap_q;
    ovf_d   = min_carry;

    if (state_q == RUN || state_q == LAP) begin
      if (period_done) begin
        pcnt_d = '0;
        tick_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + NUM_W'(1);
      end
    end

    if (clr_edge) begin
      state_d = IDLE;
      pcnt_d  = '0;
      tick_d  = 1'b0;
      snap_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run_edge) state_d = RUN;
        end
        RUN: begin
          if (run_edge) begin
            state_d = PAUSE;
          end else if (lap_edge) begin
            state_d = LAP;
            snap_d  = {min_cnt, sec_cnt};
          end
        end
        LAP: begin
          if (run_edge) begin
            state_d = PAUSE;
          end else if (lap_edge) begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (run_edge) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
      snap_q    <= '0;
      btn_run_q <= 1'b0;
      btn_lap_q <= 1'b0;
      btn_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      snap_q    <= snap_d;
      btn_run_q <= btn_run;
      btn_lap_q <= btn_lap;
      btn_clr_q <= btn_clr;
    end
  end

  assign lap_active = (state_q == LAP);
  assign running    = (state_q == RUN) || (state_q == LAP);
  assign tick_o     = tick_q;
  assign ovf        = ovf_q;
  assign sec_out    = lap_active ? snap_q[CNT_W-1:0]       : sec_cnt;
  assign min_out    = lap_active ? snap_q[2*CNT_W-1:CNT_W] : min_cnt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] num = 32'd4;
  logic        btn_run = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clr = 1'b0;
  logic [5:0]  sec_out, min_out;
  logic        tick_o, running, lap_active, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(.NUM_W(32), .SEC_MAX(59), .MIN_MAX(59)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .num        (num),
    .btn_run    (btn_run),
    .btn_lap    (btn_lap),
    .btn_clr    (btn_clr),
    .sec_out    (sec_out),
    .min_out    (min_out),
    .tick_o     (tick_o),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: elapsed time as a plain count of seconds, a "going"
  // flag (IDLE and PAUSE look identical from outside), a "frozen" flag for lap.
  bit m_going, m_frozen, m_tick, m_ovf;
  bit p_run, p_lap, p_clr;
  int m_phase, m_total, m_snap;
  bit e_run, e_lap, e_clr, new_tick;
  int period, old_total;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_going = 0; m_frozen = 0; m_tick = 0; m_ovf = 0;
      p_run = 0; p_lap = 0; p_clr = 0;
      m_phase = 0; m_total = 0; m_snap = 0;
    end else begin
      e_run = btn_run && !p_run;
      e_lap = btn_lap && !p_lap;
      e_clr = btn_clr && !p_clr;
      if (e_clr) begin
        m_going = 0; m_frozen = 0; m_tick = 0; m_ovf = 0;
        m_phase = 0; m_total = 0; m_snap = 0;
      end else begin
        period = (num == 0) ? 1 : int'(num);
        new_tick = 0;
        if (m_going) begin
          if (m_phase >= period - 1) begin
            m_phase = 0;
            new_tick = 1;
          end else begin
            m_phase = m_phase + 1;
          end
        end
        old_total = m_total;
        m_ovf = 0;
        if (m_tick) begin
          m_total = m_total + 1;
          m_ovf = (m_total % 3600) == 0;
        end
        if (e_run) begin
          m_going = !m_going;
          m_frozen = 0;
        end else if (e_lap && m_going) begin
          if (m_frozen) begin
            m_frozen = 0;
          end else begin
            m_frozen = 1;
            m_snap = old_total;
          end
        end
        m_tick = new_tick;
      end
      p_run = btn_run; p_lap = btn_lap; p_clr = btn_clr;
    end
  end

  task automatic monitor();
    forever begin
      @(negedge clk);
      begin
        int disp;
        logic [15:0] act, exp_v;
        disp = m_frozen ? m_snap : m_total;
        exp_v = {6'((disp / 60) % 60), 6'(disp % 60), m_tick, m_going, m_frozen, m_ovf};
        act = {min_out, sec_out, tick_o, running, lap_active, ovf};
        n_cmp++;
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t: got %h expected %h (min,sec,tick,run,lap,ovf)",
                   $time, act, exp_v);
        end
      end
    end
  endtask

  task automatic check(string name, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    btn_run = 1'b1; step(1); btn_run = 1'b0;
  endtask

  task automatic pulse_lap();
    btn_lap = 1'b1; step(1); btn_lap = 1'b0;
  endtask

  task automatic pulse_clr();
    btn_clr = 1'b1; step(1); btn_clr = 1'b0;
  endtask

  initial begin
    int t0, t1, waited;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_sec", sec_out, 0);
    check("reset_min", min_out, 0);
    check("reset_running", running, 0);
    check("reset_tick", tick_o, 0);
    rst_n = 1'b1;
    step(2);

    // 1: num=4 counting, first increment after num+1 edges, minute carry
    num = 4;
    pulse_run();
    step(4);
    check("t1_first_tick", tick_o, 1);
    check("t1_sec_before_first", sec_out, 0);
    step(1);
    check("t1_first_sec", sec_out, 1);
    step(235);
    check("t1_sec59", sec_out, 59);
    check("t1_min0", min_out, 0);
    step(1);
    check("t1_min1", min_out, 1);
    check("t1_sec0", sec_out, 0);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (tick_o) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
      step(1);
    end
    check("t1_tick_period", t1 - t0, 4);

    // 2: pause holds display and prescaler phase
    pulse_clr();
    pulse_run();
    step(41);
    check("t2_sec10", sec_out, 10);
    pulse_run();
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("t2_pause_hold", sec_out, 10);
    end
    check("t2_paused", running, 0);
    pulse_run();
    waited = 0;
    while (sec_out != 11 && waited < 8) begin
      step(1);
      waited++;
    end
    check("t2_resume_latency", waited, 3);

    // 3: lap freeze at 00:07, live reaches 00:12 underneath
    pulse_clr();
    pulse_run();
    step(29);
    check("t3_sec7", sec_out, 7);
    pulse_lap();
    check("t3_lap_active", lap_active, 1);
    check("t3_frozen_sec", sec_out, 7);
    step(19);
    check("t3_still_frozen", sec_out, 7);
    check("t3_running", running, 1);
    pulse_lap();
    check("t3_live_sec", sec_out, 12);
    check("t3_lap_off", lap_active, 0);
    check("t3_running_after", running, 1);

    // 4: 59:58 -> 59:59 -> 00:00 with one-cycle ovf (num=1)
    pulse_clr();
    num = 1;
    pulse_run();
    step(3599);
    check("t4_min59", min_out, 59);
    check("t4_sec58", sec_out, 58);
    step(1);
    check("t4_sec59", sec_out, 59);
    check("t4_no_ovf", ovf, 0);
    step(1);
    check("t4_wrap_min", min_out, 0);
    check("t4_wrap_sec", sec_out, 0);
    check("t4_ovf", ovf, 1);
    step(1);
    check("t4_ovf_drop", ovf, 0);

    // 5: clr and run rising together at 03:21; clr wins
    pulse_clr();
    pulse_run();
    step(202);
    check("t5_min3", min_out, 3);
    check("t5_sec21", sec_out, 21);
    btn_clr = 1'b1; btn_run = 1'b1;
    step(1);
    btn_clr = 1'b0; btn_run = 1'b0;
    check("t5_clr_sec", sec_out, 0);
    check("t5_clr_min", min_out, 0);
    check("t5_clr_running", running, 0);
    step(3);
    check("t5_idle_sec", sec_out, 0);
    pulse_run();
    step(2);
    check("t5_restart_sec", sec_out, 1);

    // 6: num=0 ticks every cycle; async reset mid-cycle
    pulse_clr();
    num = 0;
    pulse_run();
    step(1);
    check("t6_tick_num0", tick_o, 1);
    step(1);
    check("t6_sec1", sec_out, 1);
    step(1);
    check("t6_sec2", sec_out, 2);
    check("t6_tick_still", tick_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sec", sec_out, 0);
    check("t6_rst_tick", tick_o, 0);
    check("t6_rst_running", running, 0);
    step(1);
    rst_n = 1'b1;
    num = 1;
    step(2);
    check("t6_idle_after_rst", running, 0);
    pulse_run();
    step(2);
    check("t6_num1_sec1", sec_out, 1);
    check("t6_num1_tick", tick_o, 1);
    step(1);
    check("t6_num1_sec2", sec_out, 2);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
